// File: rtl/pc_fetch_unit.sv
// Program counter and circular return-address stack for the MCU fetch stage.
// One command per cycle with priority INT_ACK > RET > CALL > PC_LD > PC_INC.
module pc_fetch_unit #(
    parameter int ADDR_W = 10,
    parameter int RS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] INT_VECTOR = '1,
    localparam int LVL_W = $clog2(RS_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              pc_inc,
    input  logic              pc_ld,
    input  logic              call,
    input  logic              ret,
    input  logic              int_ack,
    input  logic [ADDR_W-1:0] from_immed,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] pc_count,
    output logic [LVL_W-1:0]  rs_level,
    output logic              rs_ovf,
    output logic              rs_unf
);
    localparam int PTR_W = $clog2(RS_DEPTH);

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [PTR_W-1:0]  ptr_reg, ptr_next;
    logic [LVL_W-1:0]  level_reg, level_next;
    logic              ovf_reg, ovf_next;
    logic              unf_reg, unf_next;
    logic              push;
    logic [ADDR_W-1:0] push_data;
    logic [PTR_W-1:0]  top_ptr;
    logic [ADDR_W-1:0] top_data;
    logic              full, empty;

    // ptr_reg is the next write slot; once full it points at the oldest entry,
    // so an overflowing push naturally overwrites it.
    logic [ADDR_W-1:0] stack_mem [RS_DEPTH];

    assign top_ptr  = ptr_reg - PTR_W'(1);
    assign top_data = stack_mem[top_ptr];
    assign full     = (level_reg == LVL_W'(RS_DEPTH));
    assign empty    = (level_reg == '0);

    always_comb begin
        pc_next    = pc_reg;
        ptr_next   = ptr_reg;
        level_next = level_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        push       = 1'b0;
        push_data  = pc_reg;
        if (!stall) begin
            if (err_clr) begin
                ovf_next = 1'b0;
                unf_next = 1'b0;
            end
            if (int_ack) begin
                push      = 1'b1;
                push_data = pc_reg;
                pc_next   = INT_VECTOR;
            end else if (ret) begin
                if (empty) begin
                    pc_next  = RESET_VECTOR;
                    unf_next = 1'b1;
                end else begin
                    pc_next    = top_data;
                    ptr_next   = top_ptr;
                    level_next = level_reg - LVL_W'(1);
                end
            end else if (call) begin
                push      = 1'b1;
                push_data = pc_reg + ADDR_W'(1);
                pc_next   = from_immed;
            end else if (pc_ld) begin
                pc_next = from_immed;
            end else if (pc_inc) begin
                pc_next = pc_reg + ADDR_W'(1);
            end
            if (push) begin
                ptr_next = ptr_reg + PTR_W'(1);
                if (full) ovf_next = 1'b1;
                else      level_next = level_reg + LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= RESET_VECTOR;
            ptr_reg   <= '0;
            level_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            ptr_reg   <= ptr_next;
            level_reg <= level_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) stack_mem[ptr_reg] <= push_data;
    end

    assign pc_count = pc_reg;
    assign rs_level = level_reg;
    assign rs_ovf   = ovf_reg;
    assign rs_unf   = unf_reg;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a queue-based stack model predicts the
// state after each edge; a monitor compares it one step after the edge.
module tb_pc_fetch_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0, pc_inc = 1'b0, pc_ld = 1'b0, call = 1'b0;
    logic       ret = 1'b0, int_ack = 1'b0, err_clr = 1'b0;
    logic [9:0] from_immed = '0;
    logic [9:0] pc_count;
    logic [3:0] rs_level;
    logic       rs_ovf, rs_unf;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc_inc(pc_inc),
        .pc_ld(pc_ld), .call(call), .ret(ret), .int_ack(int_ack),
        .from_immed(from_immed), .err_clr(err_clr), .pc_count(pc_count),
        .rs_level(rs_level), .rs_ovf(rs_ovf), .rs_unf(rs_unf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] pc;
        logic [3:0] level;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] m_stack[$];
    logic [9:0] m_pc = 10'h000;
    logic       m_ovf = 1'b0, m_unf = 1'b0;
    int         compared = 0;
    int         mismatched = 0;
    int         step_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, step_no, act, req);
        end
    endtask

    task automatic model_reset();
        m_stack.delete();
        m_pc = 10'h000;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_push(input logic [9:0] v);
        if (m_stack.size() == 8) begin
            void'(m_stack.pop_front());
            m_ovf = 1'b1;
        end
        m_stack.push_back(v);
    endtask

    // Drive one cycle's command at the falling edge and queue the expected result.
    task automatic step(input logic s, input logic i, input logic r, input logic c,
                        input logic l, input logic n, input logic e, input logic [9:0] imm);
        exp_t x;
        @(negedge clk);
        stall = s; int_ack = i; ret = r; call = c; pc_ld = l; pc_inc = n;
        err_clr = e; from_immed = imm;
        step_no++;
        if (!s) begin
            if (e) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (i) begin
                model_push(m_pc);
                m_pc = 10'h3FF;
            end else if (r) begin
                if (m_stack.size() == 0) begin
                    m_pc = 10'h000;
                    m_unf = 1'b1;
                end else begin
                    m_pc = m_stack.pop_back();
                end
            end else if (c) begin
                model_push(m_pc + 10'd1);
                m_pc = imm;
            end else if (l) begin
                m_pc = imm;
            end else if (n) begin
                m_pc = m_pc + 10'd1;
            end
        end
        x.pc = m_pc;
        x.level = 4'(m_stack.size());
        x.ovf = m_ovf;
        x.unf = m_unf;
        exp_q.push_back(x);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 10'h000);
    endtask

    task automatic jump(input logic [9:0] a);
        step(0, 0, 0, 0, 1, 0, 0, a);
    endtask

    // Directed check of current outputs, taken mid-cycle after the edge.
    task automatic settle_check(input string name, input logic [9:0] pc_req, input logic [3:0] lvl_req);
        @(posedge clk);
        #2;
        check({name, "_pc"}, 32'(pc_count), 32'(pc_req));
        check({name, "_lvl"}, 32'(rs_level), 32'(lvl_req));
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                check("pc_count", 32'(pc_count), 32'(x.pc));
                check("rs_level", 32'(rs_level), 32'(x.level));
                check("rs_ovf", 32'(rs_ovf), 32'(x.ovf));
                check("rs_unf", 32'(rs_unf), 32'(x.unf));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        #1;
        check("reset_pc", 32'(pc_count), 32'h000);
        check("reset_lvl", 32'(rs_level), 32'h0);
        check("reset_flags", 32'({rs_ovf, rs_unf}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset then increment
        repeat (4) step(0, 0, 0, 0, 0, 1, 0, 10'h000);
        settle_check("inc4", 10'h004, 4'd0);
        pc_inc = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", 32'(pc_count), 32'h000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // call / return
        jump(10'h040);
        step(0, 0, 0, 1, 0, 0, 0, 10'h120);
        step(0, 0, 0, 0, 0, 1, 0, 10'h000);
        step(0, 0, 0, 0, 0, 1, 0, 10'h000);
        step(0, 0, 1, 0, 0, 0, 0, 10'h000);
        settle_check("call_ret", 10'h041, 4'd0);

        // interrupt wins over RET and PC_INC
        jump(10'h044);
        step(0, 1, 1, 0, 0, 1, 0, 10'h000);
        settle_check("int_entry", 10'h3FF, 4'd1);
        step(0, 0, 1, 0, 0, 0, 0, 10'h000);

        // wrap-around of increment and pushed return address
        jump(10'h3FF);
        step(0, 0, 0, 0, 0, 1, 0, 10'h000);
        jump(10'h3FF);
        step(0, 0, 0, 1, 0, 0, 0, 10'h010);
        step(0, 0, 1, 0, 0, 0, 0, 10'h000);
        settle_check("wrap_ret", 10'h000, 4'd0);

        // overflow then underflow then clear
        for (int k = 0; k < 9; k++) step(0, 0, 0, 1, 0, 0, 0, 10'(10'h100 + k * 4));
        settle_check("ovf_full", 10'h120, 4'd8);
        for (int k = 0; k < 9; k++) step(0, 0, 1, 0, 0, 0, 0, 10'h000);
        step(0, 0, 0, 0, 0, 0, 1, 10'h000);

        // stall ignores CALL and ERR_CLR
        step(0, 0, 1, 0, 0, 0, 0, 10'h000);
        jump(10'h050);
        repeat (3) step(1, 0, 0, 1, 0, 0, 1, 10'h200);
        step(0, 0, 0, 0, 0, 1, 0, 10'h000);
        settle_check("stall_rel", 10'h051, 4'd0);

        // randomized mix of every command
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 8, 10'($urandom));
        end
        idle();
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
